// File: rtl/decode_writeback_param.sv
// Y86-64 decode/writeback stage: register-ID decode, register file with two
// write ports (E and M) and three read ports. Optional DECODE_WB_BYPASS_EN adds write-through reads.
module decode_writeback_param #(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       NREG     = 15,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              Cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  input  logic [3:0]        dbg_id,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] R_NONE = 4'hF;
  localparam logic [3:0] R_RSP  = 4'h4;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    srcA = R_NONE;
    srcB = R_NONE;
    dstE = R_NONE;
    dstM = R_NONE;
    case (icode)
      I_RRMOVQ: begin
        srcA = rA;
        dstE = Cnd ? rB : R_NONE;
      end
      I_IRMOVQ: dstE = rB;
      I_RMMOVQ: begin
        srcA = rA;
        srcB = rB;
      end
      I_MRMOVQ: begin
        srcB = rB;
        dstM = rA;
      end
      I_OPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      I_CALL: begin
        srcB = R_RSP;
        dstE = R_RSP;
      end
      I_RET: begin
        srcA = R_RSP;
        srcB = R_RSP;
        dstE = R_RSP;
      end
      I_PUSHQ: begin
        srcA = rA;
        srcB = R_RSP;
        dstE = R_RSP;
      end
      I_POPQ: begin
        srcA = R_RSP;
        srcB = R_RSP;
        dstE = R_RSP;
        dstM = rA;
      end
      default: ;
    endcase
  end

  // Loops compare against each implemented ID, so IDs of F or >= NREG never match.
  always_comb begin
    regs_d = regs_q;
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++)
        regs_d[i] = (i == 4) ? RSP_INIT : '0;
    end else if (wb_en) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (dstE == 4'(i)) regs_d[i] = valE;
        if (dstM == 4'(i)) regs_d[i] = valM;
      end
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] id);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NREG; i++)
      if (id == 4'(i)) v = regs_q[i];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && !reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (id == 4'(i)) begin
          if (dstM == id)      v = valM;
          else if (dstE == id) v = valE;
        end
      end
    end
`endif
    return v;
  endfunction

  always_comb begin
    valA     = read_port(srcA);
    valB     = read_port(srcB);
    dbg_data = read_port(dbg_id);
  end

endmodule

// File: tb/tb_decode_writeback_param.sv
// Scoreboard bench for decode_writeback_param: a 15-register 64-bit instance
// plus an 8-register 16-bit instance for out-of-range ID handling.
module tb_decode_writeback_param;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, wb_en, Cnd;
  logic [3:0]  icode, rA, rB, dbg_id;
  logic [63:0] valE, valM;
  logic [63:0] valA, valB, dbg_data;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [15:0] s_valA, s_valB, s_dbg_data;
  logic [3:0]  s_srcA, s_srcB, s_dstE, s_dstM;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  string       tag_q[$];
  logic [63:0] exp_q[$];

  always #50 clk = ~clk;

  decode_writeback_param #(.DATA_W(64), .NREG(15), .RSP_INIT(64'h100)) dut (
    .clk(clk), .reset(reset), .wb_en(wb_en), .icode(icode), .rA(rA), .rB(rB),
    .Cnd(Cnd), .valE(valE), .valM(valM), .valA(valA), .valB(valB),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .dbg_id(dbg_id), .dbg_data(dbg_data)
  );

  decode_writeback_param #(.DATA_W(16), .NREG(8), .RSP_INIT(16'h0BEE)) u_small (
    .clk(clk), .reset(reset), .wb_en(wb_en), .icode(icode), .rA(rA), .rB(rB),
    .Cnd(Cnd), .valE(valE[15:0]), .valM(valM[15:0]), .valA(s_valA), .valB(s_valB),
    .srcA(s_srcA), .srcB(s_srcB), .dstE(s_dstE), .dstM(s_dstM),
    .dbg_id(dbg_id), .dbg_data(s_dbg_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [63:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic observe(input logic [63:0] got);
    string       t;
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check("sb_queue_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, got, e);
    end
  endtask

  task automatic rd_reg(input logic [3:0] id);
    dbg_id = id;
    #1;
    observe(dbg_data);
  endtask

  task automatic rd_small(input logic [3:0] id);
    dbg_id = id;
    #1;
    observe(64'(s_dbg_data));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] e, input logic [63:0] m);
    icode = ic; rA = a; rB = b; Cnd = c; valE = e; valM = m;
  endtask

  task automatic nop();
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; wb_en = 1'b1; dbg_id = 4'h0;
    drive(4'h3, 4'hF, 4'h5, 1'b0, 64'h9, 64'h0);
    #1;
    expect_val("pre_reset_dstE", 64'h5);
    observe(64'(dstE));
    tick();
    reset = 1'b0; nop();
    for (int i = 0; i < 15; i++) begin
      expect_val($sformatf("rst_reg%0d", i), (i == 4) ? 64'h100 : 64'h0);
      rd_reg(4'(i));
    end
    expect_val("small_rst_rsp", 64'h0BEE);
    rd_small(4'h4);

    // irmovq $43, reg8
    drive(4'h3, 4'hF, 4'h8, 1'b0, 64'd43, 64'h0);
    #1;
    expect_val("irmov_dstE", 64'h8);
    expect_val("irmov_dstM", 64'hF);
    expect_val("small_irmov_dstE", 64'h8);
    observe(64'(dstE));
    observe(64'(dstM));
    observe(64'(s_dstE));
    expect_val("irmov_pre_edge", BYP ? 64'd43 : 64'h0);
    rd_reg(4'h8);
    tick(); nop();
    expect_val("irmov_reg8", 64'd43);
    rd_reg(4'h8);
    expect_val("small_reg8_none", 64'h0);
    rd_small(4'h8);
    expect_val("small_reg0_alias", 64'h0);
    rd_small(4'h0);

    drive(4'h4, 4'h8, 4'hA, 1'b0, 64'h0, 64'h0);
    #1;
    expect_val("rmmov_srcA", 64'h8);
    expect_val("rmmov_valA", 64'd43);
    expect_val("rmmov_srcB", 64'hA);
    expect_val("rmmov_valB", 64'h0);
    expect_val("small_srcA", 64'h8);
    expect_val("small_valA", 64'h0);
    expect_val("small_srcB", 64'hA);
    expect_val("small_valB", 64'h0);
    expect_val("small_dstM", 64'hF);
    observe(64'(srcA)); observe(valA); observe(64'(srcB)); observe(valB);
    observe(64'(s_srcA)); observe(64'(s_valA)); observe(64'(s_srcB));
    observe(64'(s_valB)); observe(64'(s_dstM));

    // cmovXX gated by Cnd
    drive(4'h2, 4'h1, 4'h2, 1'b0, 64'd7, 64'h0);
    #1;
    expect_val("cmov_nc_dstE", 64'hF);
    expect_val("cmov_srcA", 64'h1);
    observe(64'(dstE)); observe(64'(srcA));
    tick(); nop();
    expect_val("cmov_nc_reg2", 64'h0);
    rd_reg(4'h2);
    drive(4'h2, 4'h1, 4'h2, 1'b1, 64'd7, 64'h0);
    #1;
    expect_val("cmov_c_dstE", 64'h2);
    observe(64'(dstE));
    tick(); nop();
    expect_val("cmov_c_reg2", 64'd7);
    rd_reg(4'h2);

    // popq %rsp: M wins over E
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'd8, 64'd99);
    #1;
    expect_val("popsp_srcA", 64'h4);
    expect_val("popsp_srcB", 64'h4);
    expect_val("popsp_dstE", 64'h4);
    expect_val("popsp_dstM", 64'h4);
    observe(64'(srcA)); observe(64'(srcB)); observe(64'(dstE)); observe(64'(dstM));
    expect_val("popsp_pre_edge", BYP ? 64'd99 : 64'h100);
    rd_reg(4'h4);
    tick(); nop();
    expect_val("popsp_reg4", 64'd99);
    rd_reg(4'h4);

    // stall, then opq with bypass visibility
    wb_en = 1'b0;
    drive(4'h6, 4'h3, 4'h3, 1'b0, 64'd5, 64'h0);
    #1;
    expect_val("stall_dstE", 64'h3);
    observe(64'(dstE));
    tick();
    expect_val("stall_reg3", 64'h0);
    rd_reg(4'h3);
    wb_en = 1'b1;
    drive(4'h6, 4'h3, 4'h3, 1'b0, 64'd77, 64'h0);
    #1;
    expect_val("opq_pre_valA", BYP ? 64'd77 : 64'h0);
    expect_val("opq_pre_valB", BYP ? 64'd77 : 64'h0);
    observe(valA); observe(valB);
    tick(); nop();
    expect_val("opq_reg3", 64'd77);
    rd_reg(4'h3);

    // reset overrides a pending write
    reset = 1'b1;
    drive(4'h3, 4'hF, 4'h5, 1'b0, 64'h9, 64'h0);
    tick();
    reset = 1'b0; nop();
    expect_val("rst2_reg5", 64'h0);
    rd_reg(4'h5);
    expect_val("rst2_reg3", 64'h0);
    rd_reg(4'h3);
    expect_val("rst2_reg4", 64'h100);
    rd_reg(4'h4);
    expect_val("rst2_reg2", 64'h0);
    rd_reg(4'h2);

    drive(4'h5, 4'h6, 4'h2, 1'b0, 64'h0, 64'd55);
    #1;
    expect_val("mrmov_dstM", 64'h6);
    expect_val("mrmov_srcB", 64'h2);
    expect_val("mrmov_dstE", 64'hF);
    observe(64'(dstM)); observe(64'(srcB)); observe(64'(dstE));
    tick(); nop();
    expect_val("mrmov_reg6", 64'd55);
    rd_reg(4'h6);

    drive(4'hA, 4'h6, 4'hF, 1'b0, 64'hF8, 64'h0);
    #1;
    expect_val("push_srcA", 64'h6);
    expect_val("push_valA", 64'd55);
    expect_val("push_srcB", 64'h4);
    expect_val("push_valB", 64'h100);
    expect_val("push_dstE", 64'h4);
    observe(64'(srcA)); observe(valA); observe(64'(srcB)); observe(valB); observe(64'(dstE));
    tick(); nop();
    expect_val("push_reg4", 64'hF8);
    rd_reg(4'h4);

    drive(4'h8, 4'hF, 4'hF, 1'b0, 64'hF0, 64'h0);
    #1;
    expect_val("call_srcA", 64'hF);
    expect_val("call_srcB", 64'h4);
    expect_val("call_dstE", 64'h4);
    observe(64'(srcA)); observe(64'(srcB)); observe(64'(dstE));
    tick(); nop();
    expect_val("call_reg4", 64'hF0);
    rd_reg(4'h4);

    drive(4'h9, 4'hF, 4'hF, 1'b0, 64'hF8, 64'h0);
    #1;
    expect_val("ret_srcA", 64'h4);
    expect_val("ret_valA", 64'hF0);
    expect_val("ret_dstE", 64'h4);
    observe(64'(srcA)); observe(valA); observe(64'(dstE));
    tick(); nop();
    expect_val("ret_reg4", 64'hF8);
    rd_reg(4'h4);

    drive(4'hB, 4'h7, 4'hF, 1'b0, 64'h200, 64'h1234);
    tick(); nop();
    expect_val("pop_reg4", 64'h200);
    rd_reg(4'h4);
    expect_val("pop_reg7", 64'h1234);
    rd_reg(4'h7);

    drive(4'h5, 4'hE, 4'hF, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(); nop();
    expect_val("wide_reg14", 64'hFFFF_FFFF_FFFF_FFFF);
    rd_reg(4'hE);

    for (int k = 0; k < 2; k++) begin
      drive((k == 0) ? 4'h0 : 4'hC, 4'h1, 4'h1, 1'b1, 64'd5, 64'd5);
      #1;
      expect_val($sformatf("none%0d_srcA", k), 64'hF);
      expect_val($sformatf("none%0d_srcB", k), 64'hF);
      expect_val($sformatf("none%0d_dstE", k), 64'hF);
      expect_val($sformatf("none%0d_dstM", k), 64'hF);
      observe(64'(srcA)); observe(64'(srcB)); observe(64'(dstE)); observe(64'(dstM));
      tick(); nop();
      expect_val($sformatf("none%0d_reg1", k), 64'h0);
      rd_reg(4'h1);
    end

    expect_val("read_idF", 64'h0);
    rd_reg(4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_writeback_param.md
DECODE_WRITEBACK_PARAM -- requirements
Module: decode_writeback_param

Interface
REQ-001 Parameter DATA_W, default 64: register and data-path width in bits.
REQ-002 Parameter NREG, default 15: number of architectural registers, IDs 0..NREG-1; legal range 5..15.
REQ-003 Parameter RSP_INIT, default 0: reset value of register 4 (%rsp); every other register resets to 0.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 wb_en  input  1  writeback enable; low stalls all register writes for that cycle.
REQ-007 icode  input  4  Y86-64 instruction code of the current instruction.
REQ-008 rA, rB  input  4 each  register specifier fields; 4'hF = none.
REQ-009 Cnd  input  1  condition result; gates cmovXX writeback.
REQ-010 valE, valM  input  DATA_W each  ALU result and memory read data.
REQ-011 valA, valB  output  DATA_W each  operand values read from srcA/srcB.
REQ-012 srcA, srcB, dstE, dstM  output  4 each  decoded register IDs, 4'hF = none.
REQ-013 dbg_id  input  4 / dbg_data  output  DATA_W: independent combinational debug read port.

Function
REQ-014 srcA: rA for icode 2,4,6,A; 4 for icode 9,B; else F.
REQ-015 srcB: rB for icode 4,5,6; 4 for icode 8,9,A,B; else F.
REQ-016 dstE: rB for icode 3,6; rB for icode 2 only when Cnd=1, else F; 4 for icode 8,9,A,B; else F.
REQ-017 dstM: rA for icode 5,B; else F.
REQ-018 icode 0,1,7 and undefined codes (C..F): all four IDs = F, no write.
REQ-019 Any ID of F or >= NREG is "none": reads return 0, writes are discarded.
REQ-020 valA/valB/dbg_data combinational from register array (plus bypass per REQ-028); zero latency.
REQ-021 On rising clk with wb_en=1 and reset=0: reg[dstE] <= valE and reg[dstM] <= valM, both in the same cycle.
REQ-022 dstE == dstM (popq %rsp): valM is written, valE discarded.
REQ-023 wb_en=0: register array unchanged; decode outputs still track inputs.
REQ-024 Values wider than DATA_W never arise; all arithmetic is pure storage, no truncation beyond DATA_W.

Reset
REQ-025 reset=1 at rising clk: all registers cleared to 0, register 4 loaded with RSP_INIT[DATA_W-1:0]; pending writes that cycle are dropped.
REQ-026 Reset asserted mid-operation overrides wb_en and any write; first write honoured on the first rising edge with reset=0.
REQ-027 Before first reset, register contents are undefined; decode ID outputs are valid regardless of reset.

Configuration
REQ-028 Macro DECODE_WB_BYPASS_EN defined: read ports (valA, valB, dbg_data) return valM when reading dstM, else valE when reading dstE, in the same cycle as the write with wb_en=1 and reset=0 (write-through); priority M over E.
REQ-029 Macro DECODE_WB_BYPASS_EN undefined: read ports return only stored register contents; new value visible the cycle after the write.

Verification
REQ-030 reset=1, RSP_INIT=64'h100, one clk -> dbg_id=4 gives 64'h100; dbg_id=0..3,5..14 give 0.
REQ-031 icode=3, rA=F, rB=8, valE=43, wb_en=1, clk -> dstE=8, dstM=F; next cycle dbg_id=8 reads 43; then icode=4, rA=8, rB=A -> srcA=8, valA=43, srcB=A, valB=0.
REQ-032 icode=2, rA=1, rB=2, Cnd=0, valE=7, clk -> dstE=F, reg2 unchanged; repeat with Cnd=1 -> reg2=7.
REQ-033 icode=B, rA=4, valE=8, valM=99, clk -> reg4=99 (dstM wins over dstE).
REQ-034 icode=6, rB=3, valE=5, wb_en=0, clk -> reg3 unchanged; wb_en=1, clk -> reg3=5; reset=1 together with icode=3, rB=5, valE=9 -> reg5=0.
REQ-035 With DECODE_WB_BYPASS_EN: icode=6, rA=3, rB=3, valE=77 -> valA=valB=77 before the edge; without macro valA/valB show old reg3 until after edge.
